t03_prog_clock_divider: RTL and testbench



---
 rtl/t03_clkdiv_pkg.sv | 13 +
 rtl/t03_clkdiv_reload.sv | 38 +++
 rtl/t03_prog_clock_divider.sv | 90 +++++++++
 tb/tb_t03_prog_clock_divider.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/t03_clkdiv_pkg.sv
// Shared defaults and output-mode encoding for the programmable clock divider.
// Optional square-wave output is enabled with T03_CLKDIV_SQUARE_EN.
package t03_clkdiv_pkg;

    localparam int CLKDIV_CNT_W      = 23;
    localparam int CLKDIV_DEFAULT_TC = 5000000;

    typedef enum logic {
        CLKDIV_PULSE  = 1'b0,
        CLKDIV_SQUARE = 1'b1
    } clkdiv_mode_t;

endpackage

// File: rtl/t03_clkdiv_reload.sv
// Terminal-count reload slot: accepts a new count through valid/ready and
// releases it at the counter wrap, or immediately while counting is held.
module t03_clkdiv_reload
    import t03_clkdiv_pkg::*;
#(
    parameter int CNT_W = CLKDIV_CNT_W
) (
    input  logic             hwclk,
    input  logic             rst,
    input  logic             en,
    input  logic             wrap,
    input  logic [CNT_W-1:0] tc_in,
    input  logic             tc_valid,
    output logic             tc_ready,
    output logic             apply,
    output logic [CNT_W-1:0] pend_tc
);

    logic pend_v;

    assign tc_ready = ~pend_v;

    // Only one load may be outstanding, so accept and apply never coincide.
    assign apply = pend_v & (~en | wrap);

    always_ff @(posedge hwclk) begin
        if (rst) begin
            pend_v  <= 1'b0;
            pend_tc <= '0;
        end else if (apply) begin
            pend_v  <= 1'b0;
        end else if (tc_valid && tc_ready) begin
            pend_tc <= tc_in;
            pend_v  <= 1'b1;
        end
    end

endmodule

// File: rtl/t03_prog_clock_divider.sv
// Runtime-programmable clock-enable generator (pulse, or square wave when
// built with T03_CLKDIV_SQUARE_EN).
module t03_prog_clock_divider
    import t03_clkdiv_pkg::*;
#(
    parameter int CNT_W      = CLKDIV_CNT_W,
    parameter int DEFAULT_TC = CLKDIV_DEFAULT_TC
) (
    input  logic             hwclk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [CNT_W-1:0] tc_i,
    input  logic             tc_valid_i,
    output logic             tc_ready_o,
    input  logic             mode_i,
    output logic             clkdiv_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] ctr;
    logic [CNT_W-1:0] tc;
    logic [CNT_W-1:0] pend_tc;
    logic             pulse_q;
    logic             wrap;
    logic             apply;

    assign wrap  = (ctr == tc);
    assign cnt_o = ctr;

    t03_clkdiv_reload #(
        .CNT_W (CNT_W)
    ) u_reload (
        .hwclk    (hwclk),
        .rst      (rst),
        .en       (en_i),
        .wrap     (wrap),
        .tc_in    (tc_i),
        .tc_valid (tc_valid_i),
        .tc_ready (tc_ready_o),
        .apply    (apply),
        .pend_tc  (pend_tc)
    );

    always_ff @(posedge hwclk) begin
        if (rst) begin
            ctr     <= '0;
            tc      <= CNT_W'(DEFAULT_TC);
            pulse_q <= 1'b0;
        end else if (en_i) begin
            if (wrap) begin
                ctr     <= '0;
                pulse_q <= 1'b1;
                if (apply) tc <= pend_tc;
            end else begin
                ctr     <= ctr + CNT_W'(1);
                pulse_q <= 1'b0;
            end
        end else begin
            pulse_q <= 1'b0;
            // A held divider restarts its new period from zero.
            if (apply) begin
                ctr <= '0;
                tc  <= pend_tc;
            end
        end
    end

`ifdef T03_CLKDIV_SQUARE_EN
    logic         sq_q;
    clkdiv_mode_t mode;

    assign mode = clkdiv_mode_t'(mode_i);

    always_ff @(posedge hwclk) begin
        if (rst) begin
            sq_q <= 1'b0;
        end else if (en_i && wrap) begin
            sq_q <= ~sq_q;
        end
    end

    assign clkdiv_o = (mode == CLKDIV_SQUARE) ? sq_q : pulse_q;
`else
    logic unused_mode;

    assign unused_mode = mode_i;
    assign clkdiv_o    = pulse_q;
`endif

endmodule

// File: tb/tb_t03_prog_clock_divider.sv
// Directed and randomized bench for t03_prog_clock_divider (CNT_W=8, tc=4).
// Square-wave checks are included when T03_CLKDIV_SQUARE_EN is defined.
module tb_t03_prog_clock_divider;

    localparam int W   = 8;
    localparam int DTC = 4;

    logic         hwclk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [W-1:0] tc_in = '0;
    logic         tc_valid = 1'b0;
    logic         tc_ready;
    logic         mode = 1'b0;
    logic         clkdiv;
    logic [W-1:0] cnt;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference: counter position, active count, pending loads, wrap count.
    int           m_ctr;
    int           m_tc;
    int           m_wraps;
    bit           m_pulse;
    logic [W-1:0] m_pend[$];

    t03_prog_clock_divider #(
        .CNT_W      (W),
        .DEFAULT_TC (DTC)
    ) dut (
        .hwclk      (hwclk),
        .rst        (rst),
        .en_i       (en),
        .tc_i       (tc_in),
        .tc_valid_i (tc_valid),
        .tc_ready_o (tc_ready),
        .mode_i     (mode),
        .clkdiv_o   (clkdiv),
        .cnt_o      (cnt)
    );

    always #5 hwclk = ~hwclk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit exp_div();
`ifdef T03_CLKDIV_SQUARE_EN
        if (mode) return bit'(m_wraps % 2);
`endif
        return m_pulse;
    endfunction

    task automatic model_edge();
        bit accept;
        if (rst) begin
            m_ctr   = 0;
            m_tc    = DTC;
            m_wraps = 0;
            m_pulse = 0;
            m_pend.delete();
            return;
        end
        accept = tc_valid && (m_pend.size() == 0);
        if (en) begin
            if (m_ctr == m_tc) begin
                m_ctr   = 0;
                m_pulse = 1;
                m_wraps++;
                if (m_pend.size() > 0) m_tc = int'(m_pend.pop_front());
            end else begin
                m_ctr++;
                m_pulse = 0;
            end
        end else begin
            m_pulse = 0;
            if (m_pend.size() > 0) begin
                m_tc  = int'(m_pend.pop_front());
                m_ctr = 0;
            end
        end
        if (accept) m_pend.push_back(tc_in);
    endtask

    task automatic step();
        @(posedge hwclk);
        model_edge();
        #1;
        chk("m_cnt", 32'(cnt), 32'(m_ctr));
        chk("m_clkdiv", 32'(clkdiv), 32'(exp_div()));
        chk("m_ready", 32'(tc_ready), 32'(m_pend.size() == 0));
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_clkdiv", 32'(clkdiv), 32'd0);
        chk("rst_ready", 32'(tc_ready), 32'd1);

        // Default period of 5
        rst = 1'b0;
        en  = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("seq_cnt", 32'(cnt), 32'(k % 5));
            chk("seq_pulse", 32'(clkdiv), 32'(k % 5 == 0));
        end

        // Hold at ctr=3 with a load of 6
        for (int i = 0; i < 10 && m_ctr != 3; i++) step();
        chk("hold_at3", 32'(cnt), 32'd3);
        en       = 1'b0;
        tc_valid = 1'b1;
        tc_in    = 8'd6;
        step();
        chk("hold_cnt", 32'(cnt), 32'd3);
        chk("hold_ready", 32'(tc_ready), 32'd0);
        tc_valid = 1'b0;
        step();
        chk("hold_zero", 32'(cnt), 32'd0);
        chk("hold_ready2", 32'(tc_ready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("hold_div", 32'(clkdiv), 32'd0);
        end
        en = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("resume_pulse", 32'(clkdiv), 32'(k == 7));
        end

        // Mid-period load of 2 at ctr=1
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("mid_at1", 32'(cnt), 32'd1);
        tc_valid = 1'b1;
        tc_in    = 8'd2;
        step();
        chk("mid_ready", 32'(tc_ready), 32'd0);
        tc_valid = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            step();
            chk("mid_old_pulse", 32'(clkdiv), 32'(j == 3));
            chk("mid_old_ready", 32'(tc_ready), 32'(j == 3));
        end
        for (int j = 1; j <= 6; j++) begin
            step();
            chk("mid_new_pulse", 32'(clkdiv), 32'(j % 3 == 0));
        end

        // Terminal count of zero
        tc_valid = 1'b1;
        tc_in    = 8'd0;
        step();
        tc_valid = 1'b0;
        for (int i = 0; i < 6 && m_pend.size() != 0; i++) step();
        chk("tc0_applied", 32'(tc_ready), 32'd1);
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("tc0_high", 32'(clkdiv), 32'd1);
        end
`ifdef T03_CLKDIV_SQUARE_EN
        mode = 1'b1;
        for (int k = 0; k < 6; k++) step();
`endif

        // Square 5/5 (or pulse every 5), reset while the output is high
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step();
`ifdef T03_CLKDIV_SQUARE_EN
            chk("sq_level", 32'(clkdiv), 32'((k / 5) % 2 == 1));
`else
            chk("pl_level", 32'(clkdiv), 32'(k % 5 == 0));
`endif
        end
        rst = 1'b1;
        step();
        chk("mrst_cnt", 32'(cnt), 32'd0);
        chk("mrst_clkdiv", 32'(clkdiv), 32'd0);
        chk("mrst_ready", 32'(tc_ready), 32'd1);
        rst  = 1'b0;
        mode = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("mrst_tc4", 32'(clkdiv), 32'(k == 5));
        end

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            rst      = ($urandom_range(0, 99) == 0);
            en       = ($urandom_range(0, 9) != 0);
            tc_valid = ($urandom_range(0, 7) == 0);
            tc_in    = W'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
